// File: rtl/spike_rate_encoder.sv
// Rate-coding front end: eight phase-accumulator spike channels with
// double-buffered rates that switch over only at frame boundaries.
module spike_rate_encoder #(
  parameter int CHANNELS = 8,
  parameter int RATE_W   = 8,
  parameter int WINDOW   = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [RATE_W-1:0]   wr_data,
  input  logic                commit,
  output logic [CHANNELS-1:0] spike_out,
  output logic                frame_tick,
  output logic                pending
);

  localparam int              FC_W    = $clog2(WINDOW);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(WINDOW - 1);

  logic [RATE_W-1:0] shadow_r [CHANNELS];
  logic [RATE_W-1:0] active_r [CHANNELS];
  logic [RATE_W-1:0] acc_r    [CHANNELS];
  logic [FC_W-1:0]   fc_r;
  logic [RATE_W:0]   sum_s    [CHANNELS];
  logic              boundary_s;
  logic              apply_s;

  // Phase sums and frame-boundary decode
  always_comb begin
    boundary_s = ena && (fc_r == FC_LAST);
    apply_s    = boundary_s && (pending || commit);
    for (int i = 0; i < CHANNELS; i++) begin
      sum_s[i] = {1'b0, acc_r[i]} + {1'b0, active_r[i]};
    end
  end

  // Shadow and active rate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Addresses at or beyond CHANNELS match no channel and are dropped.
        if (wr_en && (int'(wr_addr) == i)) begin
          shadow_r[i] <= wr_data;
        end
        // Non-blocking read takes the shadow value from before a same-cycle write.
        if (apply_s) begin
          active_r[i] <= shadow_r[i];
        end
      end
    end
  end

  // Accumulators, spike outputs and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= '0;
      end
      spike_out  <= '0;
      frame_tick <= 1'b0;
      fc_r       <= '0;
    end else if (ena) begin
      for (int i = 0; i < CHANNELS; i++) begin
        spike_out[i] <= sum_s[i][RATE_W];
        // A rate switch restarts every phase so the new frame's counts are exact.
        acc_r[i]     <= apply_s ? '0 : sum_s[i][RATE_W-1:0];
      end
      frame_tick <= boundary_s;
      fc_r       <= boundary_s ? '0 : fc_r + FC_W'(1);
    end else begin
      spike_out  <= '0;
      frame_tick <= 1'b0;
    end
  end

  // Outstanding commit request
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (apply_s) begin
      pending <= 1'b0;
    end else if (commit) begin
      pending <= 1'b1;
    end else begin
      pending <= pending;
    end
  end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-coding front end for the LIF spiking network. It turns eight host-programmed 8-bit intensities into eight per-cycle spike trains and drives them straight into the network's per-neuron `current` inputs. Each channel uses a carry-out phase accumulator, so a channel programmed with rate R emits exactly R spikes per 256 enabled cycles. New rates are double-buffered and take effect only at a frame boundary, so a measurement window never mixes two rate sets.

## Interface
- `CHANNELS`, default 8: number of spike channels; equals the network's input width.
- `RATE_W`, default 8: intensity width; accumulator modulus is 2^RATE_W.
- `WINDOW`, default 256: frame length in enabled cycles, ≥2.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `ena`  in  1: advance enable; when low, all encoding state holds.
- `wr_en`  in  1: write strobe for the shadow rate register addressed by `wr_addr`.
- `wr_addr`  in  3: channel index; values ≥ `CHANNELS` are ignored.
- `wr_data`  in  `RATE_W`: rate value to write.
- `commit`  in  1: one-cycle request to copy shadow rates to active rates at the next frame boundary.
- `spike_out`  out  `CHANNELS`: registered spike bits; connects to the network's `current`.
- `frame_tick`  out  1: registered one-cycle pulse marking the last cycle of each frame.
- `pending`  out  1: a commit has been requested and not yet applied.

## Operation
- State:
  - `shadow[i]` and `active[i]`, each `RATE_W` bits.
  - `acc[i]`, `RATE_W` bits.
  - Frame counter `fc`, 0..`WINDOW`-1.
  - `pending` flag.
- Reset (`rst`=1): shadow, active, acc, fc, `spike_out`, `frame_tick` and `pending` all go to 0. Reset has priority over every other input in the same cycle.
- Write: when `wr_en`=1 and `wr_addr`<`CHANNELS`, `shadow[wr_addr]` <= `wr_data`. Writes are accepted regardless of `ena` and never affect `active` directly.
- Encode (`ena`=1), per channel:
  - {c, s} = acc[i] + active[i], computed at `RATE_W`+1 bits.
  - `spike_out[i]` <= c and `acc[i]` <= s.
  - Wrap-around of s is the intended modulo behaviour. Rate 0 never spikes; rate 255 spikes 255 of every 256 cycles.
- Frame counter: on each `ena` cycle, fc <= (fc==`WINDOW`-1) ? 0 : fc+1. `frame_tick` <= `ena` && fc==`WINDOW`-1.
- Boundary event B = `ena` && fc==`WINDOW`-1. Let "request" = `pending` \|\| `commit` this cycle. On B with request:
  - active <= shadow, using the shadow value before any same-cycle write.
  - All acc <= 0; this overrides the encode update.
  - `pending` <= 0.
  - `spike_out` for cycle B is still computed from the old active rates and old acc.
- Commit off-boundary: `commit`=1 when not B sets `pending` <= 1. A repeated commit while pending has no extra effect.
- `ena`=0: `spike_out` <= 0 and `frame_tick` <= 0. acc, fc and active hold. `pending` can still be set by `commit`, but no boundary can fire.
- Spike count per frame is exact (= active[i] × `WINDOW`/256 when `WINDOW` is a multiple of 256) for every frame that starts with acc=0, i.e. the first frame after reset and every frame after a commit.

## Timing
- Latency: rate/acc state to `spike_out` is 1 cycle (registered). Write to `shadow` is 1 cycle.
- Commit to active: takes effect on the cycle after the next B. The first spikes using the new rates appear 1 cycle after that.
- `frame_tick` is asserted in the same cycle as the spike bits of the frame's last cycle.
- Rising `rst` mid-frame clears everything on the next edge. Pending commits and written shadow values are lost.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
1. Reset, `ena`=1, no writes, run 600 cycles -> `spike_out`=0 throughout; `frame_tick` pulses at cycles 256 and 512 after reset release; `pending`=0.
2. Write ch0=128, pulse `commit` at cycle 10 -> `pending`=1 from cycle 11 until the first `frame_tick`, then 0. In the next frame ch0 spikes on every second cycle (first spike on the 2nd cycle), exactly 128 spikes.
3. Write ch7=255, ch3=1, ch5=0, commit -> the following frame counts are ch7=255, ch3=1, ch5=0, others 0. Counts repeat identically for 3 frames.
4. After step 3, write ch7=16 without commit -> ch7 stays at 255 spikes per frame for 2 frames. Then commit -> 16 spikes in the frame after the next boundary.
5. With rates active, drop `ena` for 10 cycles mid-frame -> `spike_out`=0 during the gap; `frame_tick` is delayed by exactly 10 cycles; per-frame spike counts are unchanged.
6. Commit pending mid-frame, assert `rst` for 1 cycle -> next cycle all outputs are 0 and `pending`=0. After re-enabling, no spikes occur and the old shadow rates are not applied at the next boundary.
